fp_norm_round: RTL and testbench
================================

FP_NORM_ROUND -- requirements
Module: fp_norm_round

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width (significand incl. hidden bit = MAN_W+1).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream operand valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand.
REQ-007 SHALL have port sign  input  1  result sign from the add/sub path.
REQ-008 SHALL have port exp_in  input  EXP_W  larger aligned operand's biased exponent.
REQ-009 SHALL have port sum_in  input  MAN_W+1  significand sum from the mantissa carry-lookahead adder.
REQ-010 SHALL have port cout_in  input  1  adder carry out.
REQ-011 SHALL have port grs_in  input  3  guard, round, sticky bits from alignment, MSB = guard.
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have port result  output  1+EXP_W+MAN_W  packed IEEE-754 result {sign, exp, frac}.
REQ-015 SHALL have port overflow  output  1  result rounded to infinity.
REQ-016 SHALL have port underflow  output  1  result subnormal or zero and inexact.

Function
REQ-017 SHALL capture inputs when in_valid && in_ready; in_ready = 1 only in IDLE.
REQ-018 SHALL implement FSM IDLE -> NORM -> ROUND -> DONE -> IDLE.
REQ-019 SHALL, in NORM with cout_in = 1, shift {cout,sum} right by one, exp+1, shifted-out bit -> guard, guard -> round, round|sticky -> sticky; then go to ROUND.
REQ-020 SHALL, in NORM with cout = 0, shift left one bit per cycle (guard shifted into LSB, round -> guard, 0 -> round, sticky unchanged), exp-1, until significand MSB = 1 or exp = 1.
REQ-021 SHALL treat sum = 0, cout = 0, grs = 0 as exact zero: result = all-zero (+0), flags 0, skipping to DONE after one NORM cycle.
REQ-022 SHALL round to nearest, ties to even: increment when G && (R || S || LSB).
REQ-023 SHALL, when rounding carries out of the significand, shift right one and exp+1.
REQ-024 SHALL, when exp reaches 2^EXP_W-1, output infinity (frac = 0) with overflow = 1.
REQ-025 SHALL encode exp field 0 when the final significand MSB = 0 (subnormal); underflow = 1 if additionally G|R|S was nonzero before rounding.
REQ-026 SHALL hold result, flags, out_valid stable in DONE until out_ready = 1; transfer returns to IDLE the following cycle.
REQ-027 SHALL have latency from accept to out_valid = 3 cycles (right shift / already normal), up to MAN_W+3 cycles (iterative left shift).

Reset
REQ-028 SHALL, on rst, go to IDLE with in_ready = 1, out_valid = 0, result = 0, overflow = 0, underflow = 0.
REQ-029 SHALL abort any in-flight operation on rst without emitting it; rst overrides in_valid in the same cycle.

Configuration
REQ-030 SHALL support macro FP_NORM_FAST_LZC_EN: when defined, NORM completes in one cycle using a leading-zero counter (shift = min(lzc, exp-1)), fixed latency 3 cycles; when undefined, the iterative left shift of REQ-020 is used. Results SHALL be bit-identical in both builds.

Structure
REQ-031 SHALL place EXP_W/MAN_W defaults, exponent bias, FSM state encoding and GRS bit indices in shared package fp_pkg.
REQ-032 SHALL use one sub-module fp_lzc (leading-zero count of MAN_W+1 bits), instantiated only under FP_NORM_FAST_LZC_EN.

Verification
REQ-033 SHALL test exp=127, cout=1, sum=0x800000, grs=0 -> result 0x40400000 (3.0), flags 0, latency 3.
REQ-034 SHALL test exp=130, cout=0, sum=0x200000, grs=0 -> result 0x40000000 after 2 shift cycles (iterative build).
REQ-035 SHALL test exp=127, cout=0, sum=0xFFFFFF, grs=100 -> tie rounds up, renormalises, result 0x40000000.
REQ-036 SHALL test exp=254, cout=1, sum=0x800000 -> result 0x7F800000, overflow=1.
REQ-037 SHALL test sum=0, cout=0, grs=0, sign=1 -> result 0x00000000; and out_ready held 0 for 5 cycles -> result/out_valid stable, in_ready=0.
REQ-038 SHALL test rst asserted mid-NORM -> next cycle out_valid=0, in_ready=1, no result emitted.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point normalise/round block:
// format defaults, exponent bias, GRS bit positions and FSM state encoding.
package fp_pkg;

    localparam int unsigned EXP_W_DEF = 8;
    localparam int unsigned MAN_W_DEF = 23;
    localparam int unsigned EXP_BIAS  = (1 << (EXP_W_DEF - 1)) - 1;

    // Bit positions inside the 3-bit guard/round/sticky vector
    localparam int unsigned GRS_G = 2;
    localparam int unsigned GRS_R = 1;
    localparam int unsigned GRS_S = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; returns W when the input is all zero.
module fp_lzc #(
    parameter int unsigned W = 24,
    localparam int unsigned CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     value,
    output logic [CNT_W-1:0] count_c
);

    // Scan upward so the highest set bit has the final say
    always_comb begin
        count_c = CNT_W'(W);
        for (int i = 0; i < W; i++) begin
            if (value[i]) begin
                count_c = CNT_W'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_norm_round.sv
// Post-add normalise and round-to-nearest-even stage producing a packed IEEE-754 result.
// Define FP_NORM_FAST_LZC_EN for single-cycle normalisation via fp_lzc.
module fp_norm_round
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = EXP_W_DEF,
    parameter int unsigned MAN_W = MAN_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   sign,
    input  logic [EXP_W-1:0]       exp_in,
    input  logic [MAN_W:0]         sum_in,
    input  logic                   cout_in,
    input  logic [2:0]             grs_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int unsigned SIG_W = MAN_W + 1;
    localparam int unsigned RND_W = SIG_W + 1;
    localparam int unsigned EI_W  = EXP_W + 2;
    localparam int unsigned RES_W = 1 + EXP_W + MAN_W;

    localparam logic [EI_W-1:0] EXP_ONE = EI_W'(1);
    localparam logic [EI_W-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};

    state_t             state_q, state_d;
    logic               sign_q, sign_d;
    logic [EI_W-1:0]    exp_q, exp_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic               cout_q, cout_d;
    logic [2:0]         grs_q, grs_d;
    logic [RES_W-1:0]   result_d;
    logic               overflow_d, underflow_d;
    logic               in_ready_d, out_valid_d;

    // Rounding datapath, evaluated from the normalised registers
    logic               inc_c;
    logic [RND_W-1:0]   sig_rnd_c;
    logic [SIG_W-1:0]   sig_fin_c;
    logic [EI_W-1:0]    exp_fin_c;

    assign inc_c     = grs_q[GRS_G] & (grs_q[GRS_R] | grs_q[GRS_S] | sig_q[0]);
    assign sig_rnd_c = {1'b0, sig_q} + RND_W'(inc_c);
    assign sig_fin_c = sig_rnd_c[SIG_W] ? sig_rnd_c[SIG_W:1] : sig_rnd_c[SIG_W-1:0];
    assign exp_fin_c = sig_rnd_c[SIG_W] ? exp_q + EXP_ONE : exp_q;

`ifdef FP_NORM_FAST_LZC_EN
    localparam int unsigned LZ_W = $clog2(SIG_W + 1);

    logic [LZ_W-1:0]    lzc_c;
    logic [EI_W-1:0]    lead_c;
    logic [EI_W-1:0]    max_sh_c;
    logic [EI_W-1:0]    sh_c;
    logic [SIG_W+1:0]   norm_vec_c;

    fp_lzc #(.W(SIG_W)) u_lzc (
        .value   (sig_q),
        .count_c (lzc_c)
    );

    // Guard and round continue the significand so the full left shift
    // matches the bit-at-a-time walk, clamped so exp never drops below 1
    always_comb begin
        if (sig_q != '0) begin
            lead_c = EI_W'(lzc_c);
        end else if (grs_q[GRS_G]) begin
            lead_c = EI_W'(SIG_W);
        end else if (grs_q[GRS_R]) begin
            lead_c = EI_W'(SIG_W + 1);
        end else begin
            lead_c = '1;
        end
        max_sh_c   = (exp_q > EXP_ONE) ? exp_q - EXP_ONE : '0;
        sh_c       = (lead_c < max_sh_c) ? lead_c : max_sh_c;
        norm_vec_c = {sig_q, grs_q[GRS_G], grs_q[GRS_R]} << sh_c;
    end
`else
    logic [SIG_W-1:0]   sig_l_c;
    logic [EI_W-1:0]    exp_l_c;

    assign sig_l_c = {sig_q[SIG_W-2:0], grs_q[GRS_G]};
    assign exp_l_c = exp_q - EXP_ONE;
`endif

    // Next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        sig_d       = sig_q;
        cout_d      = cout_q;
        grs_d       = grs_q;
        result_d    = result;
        overflow_d  = overflow;
        underflow_d = underflow;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_d  = sign;
                    exp_d   = {2'b00, exp_in};
                    sig_d   = sum_in;
                    cout_d  = cout_in;
                    grs_d   = grs_in;
                    state_d = ST_NORM;
                end
            end

            ST_NORM: begin
                if (cout_q) begin
                    sig_d   = {1'b1, sig_q[SIG_W-1:1]};
                    grs_d   = {sig_q[0], grs_q[GRS_G], grs_q[GRS_R] | grs_q[GRS_S]};
                    exp_d   = exp_q + EXP_ONE;
                    cout_d  = 1'b0;
                    state_d = ST_ROUND;
                end else if (sig_q == '0 && grs_q == '0) begin
                    result_d    = '0;
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
                    state_d     = ST_DONE;
                end else begin
`ifdef FP_NORM_FAST_LZC_EN
                    sig_d   = norm_vec_c[SIG_W+1:2];
                    grs_d   = {norm_vec_c[1], norm_vec_c[0], grs_q[GRS_S]};
                    exp_d   = exp_q - sh_c;
                    state_d = ST_ROUND;
`else
                    if (sig_q[SIG_W-1] || exp_q <= EXP_ONE) begin
                        state_d = ST_ROUND;
                    end else begin
                        sig_d = sig_l_c;
                        grs_d = {grs_q[GRS_R], 1'b0, grs_q[GRS_S]};
                        exp_d = exp_l_c;
                        if (sig_l_c[SIG_W-1] || exp_l_c <= EXP_ONE) begin
                            state_d = ST_ROUND;
                        end
                    end
`endif
                end
            end

            ST_ROUND: begin
                if (exp_fin_c >= EXP_MAX) begin
                    result_d    = {sign_q, {EXP_W{1'b1}}, MAN_W'(0)};
                    overflow_d  = 1'b1;
                    underflow_d = 1'b0;
                end else if (!sig_fin_c[SIG_W-1]) begin
                    result_d    = {sign_q, EXP_W'(0), sig_fin_c[MAN_W-1:0]};
                    overflow_d  = 1'b0;
                    underflow_d = |grs_q;
                end else begin
                    result_d    = {sign_q, exp_fin_c[EXP_W-1:0], sig_fin_c[MAN_W-1:0]};
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
                end
                state_d = ST_DONE;
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            sig_q     <= '0;
            cout_q    <= 1'b0;
            grs_q     <= '0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            exp_q     <= exp_d;
            sig_q     <= sig_d;
            cout_q    <= cout_d;
            grs_q     <= grs_d;
            result    <= result_d;
            overflow  <= overflow_d;
            underflow <= underflow_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed vector bench for fp_norm_round (single precision), with stall and abort sequences.
module tb_fp_norm_round;
    import fp_pkg::*;

    localparam logic [7:0] B = 8'(EXP_BIAS);
    localparam int NVEC = 21;
    localparam int MAX_WAIT = 200;

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] sum;
        logic        cout;
        logic [2:0]  grs;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        int          lat_it;
        int          lat_fast;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sign;
    logic [7:0]  exp_in;
    logic [23:0] sum_in;
    logic        cout_in;
    logic [2:0]  grs_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[NVEC];

    fp_norm_round dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign      (sign),
        .exp_in    (exp_in),
        .sum_in    (sum_in),
        .cout_in   (cout_in),
        .grs_in    (grs_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        sign    = v.sign;
        exp_in  = v.exp;
        sum_in  = v.sum;
        cout_in = v.cout;
        grs_in  = v.grs;
    endtask

    // Apply one operand, measure latency, optionally stall the output, then drain
    task automatic run_vec(input string tag, input vec_t v, input int stall);
        int lat;
        int exp_lat;
`ifdef FP_NORM_FAST_LZC_EN
        exp_lat = v.lat_fast;
`else
        exp_lat = v.lat_it;
`endif
        check($sformatf("%s in_ready before accept", tag), 32'(in_ready), 32'd1);
        drive(v);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < MAX_WAIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("%s latency", tag), 32'(lat), 32'(exp_lat));
        check($sformatf("%s result", tag), result, v.res);
        check($sformatf("%s overflow", tag), 32'(overflow), 32'(v.ovf));
        check($sformatf("%s underflow", tag), 32'(underflow), 32'(v.unf));
        for (int k = 0; k < stall; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s stall%0d out_valid", tag, k), 32'(out_valid), 32'd1);
            check($sformatf("%s stall%0d result", tag, k), result, v.res);
            check($sformatf("%s stall%0d in_ready", tag, k), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check($sformatf("%s out_valid after transfer", tag), 32'(out_valid), 32'd0);
        check($sformatf("%s in_ready after transfer", tag), 32'(in_ready), 32'd1);
    endtask

    initial begin
        vec_t zs;
        int   seen;

        //          sign  exp     sum         cout  grs     result          ovf   unf   it  fast
        vecs[0]  = '{1'b0, B,      24'h800000, 1'b0, 3'b000, 32'h3F800000, 1'b0, 1'b0, 3,  3};
        vecs[1]  = '{1'b0, 8'd127, 24'h800000, 1'b1, 3'b000, 32'h40400000, 1'b0, 1'b0, 3,  3};
        vecs[2]  = '{1'b0, 8'd130, 24'h200000, 1'b0, 3'b000, 32'h40000000, 1'b0, 1'b0, 4,  3};
        vecs[3]  = '{1'b0, 8'd127, 24'hFFFFFF, 1'b0, 3'b100, 32'h40000000, 1'b0, 1'b0, 3,  3};
        vecs[4]  = '{1'b0, 8'd254, 24'h800000, 1'b1, 3'b000, 32'h7F800000, 1'b1, 1'b0, 3,  3};
        vecs[5]  = '{1'b1, 8'd100, 24'h000000, 1'b0, 3'b000, 32'h00000000, 1'b0, 1'b0, 2,  2};
        vecs[6]  = '{1'b0, 8'd127, 24'h800000, 1'b0, 3'b100, 32'h3F800000, 1'b0, 1'b0, 3,  3};
        vecs[7]  = '{1'b0, 8'd127, 24'h800000, 1'b0, 3'b110, 32'h3F800001, 1'b0, 1'b0, 3,  3};
        vecs[8]  = '{1'b0, 8'd127, 24'h800000, 1'b0, 3'b011, 32'h3F800000, 1'b0, 1'b0, 3,  3};
        vecs[9]  = '{1'b1, 8'd127, 24'h800000, 1'b0, 3'b000, 32'hBF800000, 1'b0, 1'b0, 3,  3};
        vecs[10] = '{1'b0, 8'd127, 24'h800001, 1'b1, 3'b000, 32'h40400000, 1'b0, 1'b0, 3,  3};
        vecs[11] = '{1'b0, 8'd127, 24'h800001, 1'b1, 3'b001, 32'h40400001, 1'b0, 1'b0, 3,  3};
        vecs[12] = '{1'b0, 8'd127, 24'h400000, 1'b0, 3'b110, 32'h3F000002, 1'b0, 1'b0, 3,  3};
        vecs[13] = '{1'b0, 8'd1,   24'h400000, 1'b0, 3'b000, 32'h00400000, 1'b0, 1'b0, 3,  3};
        vecs[14] = '{1'b0, 8'd1,   24'h400000, 1'b0, 3'b011, 32'h00400000, 1'b0, 1'b1, 3,  3};
        vecs[15] = '{1'b0, 8'd1,   24'h7FFFFF, 1'b0, 3'b110, 32'h00800000, 1'b0, 1'b0, 3,  3};
        vecs[16] = '{1'b0, 8'd3,   24'h100000, 1'b0, 3'b000, 32'h00400000, 1'b0, 1'b0, 4,  3};
        vecs[17] = '{1'b0, 8'd127, 24'h000001, 1'b0, 3'b000, 32'h34000000, 1'b0, 1'b0, 25, 3};
        vecs[18] = '{1'b0, 8'd127, 24'h000000, 1'b0, 3'b100, 32'h33800000, 1'b0, 1'b0, 26, 3};
        vecs[19] = '{1'b0, 8'd5,   24'h000000, 1'b0, 3'b001, 32'h00000000, 1'b0, 1'b1, 6,  3};
        vecs[20] = '{1'b0, 8'd254, 24'hFFFFFF, 1'b0, 3'b110, 32'h7F800000, 1'b1, 1'b0, 3,  3};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", result, 32'h0);
        check("reset overflow", 32'(overflow), 32'd0);
        check("reset underflow", 32'(underflow), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i], 0);
        end

        // Exact zero with negative sign, held in DONE by a stalled consumer
        zs = vecs[5];
        run_vec("stall zero", zs, 5);
        run_vec("stall 3.0", vecs[1], 3);

        // Reset during normalisation, with a competing operand offered in the reset cycle
        drive(vecs[17]);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("abort busy in NORM", 32'(in_ready), 32'd0);
        drive(vecs[1]);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort result", result, 32'h0);
        check("abort overflow", 32'(overflow), 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("abort no emit", 32'(seen), 32'd0);
        run_vec("recover", vecs[3], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule
